// File: rtl/sync_filter_block.sv
// sync_filter_block: per-channel CDC synchronizer plus glitch filter with edge strobes and a glitch counter
module sync_filter_block #(
  parameter int                 C_WIDTH         = 4,
  parameter int                 C_NUM_SYNC_REGS = 3,
  parameter int                 C_FILTER_CYCLES = 8,
  parameter logic [C_WIDTH-1:0] C_RESET_VAL     = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [C_WIDTH-1:0] data_in,
  input  logic               filter_en,
  input  logic               glitch_clr,
  output logic [C_WIDTH-1:0] data_out,
  output logic [C_WIDTH-1:0] rise_pulse,
  output logic [C_WIDTH-1:0] fall_pulse,
  output logic [15:0]        glitch_cnt
);
  localparam int CW = $clog2(C_FILTER_CYCLES + 1);
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic [C_WIDTH-1:0] sync_q [C_NUM_SYNC_REGS];
  logic [CW-1:0]      cnt_q [C_WIDTH];
  logic [CW-1:0]      cnt_d [C_WIDTH];
  logic [C_WIDTH-1:0] s, dout_q, dout_d, rise_q, fall_q;
  logic [15:0]        gcnt_q, gcnt_d;
  logic               glitch;
  assign s = sync_q[C_NUM_SYNC_REGS-1];
  always_comb begin
    dout_d = dout_q;
    glitch = 1'b0;
    for (int i = 0; i < C_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (!filter_en) dout_d[i] = s[i];
      else if (s[i] == dout_q[i]) glitch = glitch | (cnt_q[i] != '0);
      else if (cnt_q[i] == CW'(C_FILTER_CYCLES - 1)) dout_d[i] = s[i];
      else cnt_d[i] = cnt_q[i] + 1'b1;
    end
    gcnt_d = glitch_clr ? '0 : (glitch && gcnt_q != 16'hFFFF) ? gcnt_q + 16'd1 : gcnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < C_NUM_SYNC_REGS; k++) sync_q[k] <= C_RESET_VAL;
      for (int i = 0; i < C_WIDTH; i++) cnt_q[i] <= '0;
      dout_q <= C_RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      gcnt_q <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int k = 1; k < C_NUM_SYNC_REGS; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < C_WIDTH; i++) cnt_q[i] <= cnt_d[i];
      dout_q <= dout_d;
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
      gcnt_q <= gcnt_d;
    end
  end
  assign data_out   = dout_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign glitch_cnt = gcnt_q;
endmodule

// File: tb/tb_sync_filter_block.sv
// tb_sync_filter_block: scoreboard bench for sync_filter_block (4-channel default and 1-channel N=2,F=1)
module tb_sync_filter_block;
  localparam int DOUT = 0, RISE = 1, FALL = 2, GCNT = 3, D2OUT = 4, D2RISE = 5;
  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    string       tag;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1, filter_en = 1'b1, glitch_clr = 1'b0;
  logic [3:0]  data_in = 4'h0, data_out, rise_pulse, fall_pulse;
  logic [15:0] glitch_cnt, g2_cnt;
  logic [0:0]  d2_in = 1'b0, d2_out, r2, f2;
  logic        d2_en = 1'b1;
  int          cyc = 0, n_chk = 0, n_pass = 0;
  exp_t        sbq[$];
  sync_filter_block dut (
    .clk(clk), .reset(reset), .data_in(data_in), .filter_en(filter_en), .glitch_clr(glitch_clr),
    .data_out(data_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .glitch_cnt(glitch_cnt)
  );
  sync_filter_block #(.C_WIDTH(1), .C_NUM_SYNC_REGS(2), .C_FILTER_CYCLES(1), .C_RESET_VAL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .data_in(d2_in), .filter_en(d2_en), .glitch_clr(1'b0),
    .data_out(d2_out), .rise_pulse(r2), .fall_pulse(f2), .glitch_cnt(g2_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask
  function automatic logic [15:0] sig(input int sel);
    case (sel)
      DOUT:    return 16'(data_out);
      RISE:    return 16'(rise_pulse);
      FALL:    return 16'(fall_pulse);
      GCNT:    return glitch_cnt;
      D2OUT:   return 16'(d2_out);
      default: return 16'(r2);
    endcase
  endfunction
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].cyc == cyc) begin
        chk(sbq[i].tag, sig(sbq[i].sel), sbq[i].exp);
        sbq.delete(i);
      end
  end
  task automatic exp_at(input int dly, input int sel, input logic [15:0] v, input string tag);
    sbq.push_back('{cyc + dly, sel, v, tag});
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic settle();
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      step(1);
      t++;
    end
    chk("sb_drain", 16'(sbq.size()), 16'd0);
    sbq.delete();
  endtask
  initial begin
    step(2);
    chk("rst_dout", 16'(data_out), 16'h0);
    chk("rst_rise", 16'(rise_pulse), 16'h0);
    chk("rst_fall", 16'(fall_pulse), 16'h0);
    chk("rst_gcnt", glitch_cnt, 16'h0);
    reset = 1'b0;
    data_in = 4'h1;
    exp_at(10, DOUT, 16'h0, "t1_dout_early");
    exp_at(11, DOUT, 16'h1, "t1_dout");
    exp_at(10, RISE, 16'h0, "t1_rise_early");
    exp_at(11, RISE, 16'h1, "t1_rise");
    exp_at(12, RISE, 16'h0, "t1_rise_end");
    exp_at(12, FALL, 16'h0, "t1_fall");
    exp_at(11, GCNT, 16'h0, "t1_gcnt");
    settle();
    data_in = 4'h3;
    exp_at(8, GCNT, 16'd0, "t2_gcnt_pre");
    exp_at(9, GCNT, 16'd1, "t2_gcnt");
    exp_at(9, DOUT, 16'h1, "t2_dout");
    exp_at(12, DOUT, 16'h1, "t2_dout_late");
    exp_at(12, RISE, 16'h0, "t2_rise");
    step(5);
    data_in = 4'h1;
    settle();
    data_in = 4'hD;
    exp_at(6, GCNT, 16'd1, "t2b_gcnt_pre");
    exp_at(7, GCNT, 16'd2, "t2b_gcnt");
    exp_at(10, DOUT, 16'h1, "t2b_dout");
    step(3);
    data_in = 4'h1;
    settle();
    filter_en = 1'b0;
    data_in = 4'h0;
    step(6);
    data_in = 4'hF;
    exp_at(3, DOUT, 16'h0, "t3_dout_early");
    exp_at(4, DOUT, 16'hF, "t3_dout");
    exp_at(4, RISE, 16'hF, "t3_rise");
    exp_at(5, RISE, 16'h0, "t3_rise_end");
    exp_at(4, FALL, 16'h0, "t3_fall_quiet");
    step(6);
    data_in = 4'h0;
    exp_at(4, DOUT, 16'h0, "t3_dout_fall");
    exp_at(4, FALL, 16'hF, "t3_fall");
    exp_at(5, FALL, 16'h0, "t3_fall_end");
    exp_at(4, RISE, 16'h0, "t3_rise_quiet");
    exp_at(4, GCNT, 16'd2, "t3_gcnt");
    settle();
    filter_en = 1'b1;
    step(2);
    for (int i = 0; i < 65600; i++) begin
      data_in = i[0] ? 4'h2 : 4'h1;
      step(1);
    end
    exp_at(0, GCNT, 16'hFFFF, "t4_sat");
    exp_at(0, DOUT, 16'h0, "t4_dout");
    data_in = 4'h1;
    step(1);
    exp_at(0, GCNT, 16'hFFFF, "t4_sat_hold");
    data_in = 4'h2;
    glitch_clr = 1'b1;
    exp_at(1, GCNT, 16'h0, "t4_clr_wins");
    step(1);
    glitch_clr = 1'b0;
    data_in = 4'h0;
    step(12);
    glitch_clr = 1'b1;
    exp_at(1, GCNT, 16'h0, "t4_clr");
    step(1);
    glitch_clr = 1'b0;
    settle();
    data_in = 4'h8;
    exp_at(11, DOUT, 16'h8, "t5_pre_dout");
    settle();
    step(2);
    data_in = 4'hC;
    step(8);
    reset = 1'b1;
    #1;
    chk("t5_async_dout", 16'(data_out), 16'h0);
    chk("t5_async_rise", 16'(rise_pulse), 16'h0);
    chk("t5_async_fall", 16'(fall_pulse), 16'h0);
    chk("t5_async_gcnt", glitch_cnt, 16'h0);
    step(1);
    reset = 1'b0;
    exp_at(1, RISE, 16'h0, "t5_rel_rise");
    exp_at(1, FALL, 16'h0, "t5_rel_fall");
    exp_at(10, DOUT, 16'h0, "t5_refilter_early");
    exp_at(11, DOUT, 16'hC, "t5_refilter");
    exp_at(11, RISE, 16'hC, "t5_rise");
    exp_at(12, RISE, 16'h0, "t5_rise_end");
    settle();
    d2_en = 1'b1;
    d2_in = 1'b1;
    exp_at(2, D2OUT, 16'h0, "t6_filt_early");
    exp_at(3, D2OUT, 16'h1, "t6_filt");
    exp_at(3, D2RISE, 16'h1, "t6_rise");
    exp_at(4, D2RISE, 16'h0, "t6_rise_end");
    settle();
    d2_en = 1'b0;
    d2_in = 1'b0;
    exp_at(2, D2OUT, 16'h1, "t6_byp_early");
    exp_at(3, D2OUT, 16'h0, "t6_byp");
    settle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
